// File: rtl/vx_tlb_xlate_if.sv
// Translation channel bundle: virtual request in, physical request out, and the PTE fetch port.
interface vx_tlb_xlate_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 16,
  parameter int PTE_WIDTH  = 32
);
  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQS-1:0]            req_ready;
  logic [NUM_REQS-1:0]            out_valid;
  logic [NUM_REQS*ADDR_WIDTH-1:0] out_addr;
  logic [NUM_REQS*TAG_WIDTH-1:0]  out_tag;
  logic [NUM_REQS-1:0]            out_ready;
  logic                           ptw_req_valid;
  logic [ADDR_WIDTH-1:0]          ptw_req_addr;
  logic                           ptw_req_ready;
  logic                           ptw_rsp_valid;
  logic [PTE_WIDTH-1:0]           ptw_rsp_data;

  modport master (
    output req_valid, req_addr, req_tag, out_ready, ptw_req_ready, ptw_rsp_valid, ptw_rsp_data,
    input  req_ready, out_valid, out_addr, out_tag, ptw_req_valid, ptw_req_addr
  );

  modport slave (
    input  req_valid, req_addr, req_tag, out_ready, ptw_req_ready, ptw_rsp_valid, ptw_rsp_data,
    output req_ready, out_valid, out_addr, out_tag, ptw_req_valid, ptw_req_addr
  );
endinterface

// File: rtl/vx_tlb_xlate.sv
// Multi-channel fully-associative TLB with a single round-robin page-table walker.
module vx_tlb_xlate #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 16,
  parameter int TLB_SIZE   = 16,
  parameter int PAGE_BITS  = 12,
  parameter int PTE_WIDTH  = 32
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pt_base,
  vx_tlb_xlate_if.slave         bus,
  output logic                  fault_valid,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic                  busy
);
  localparam int PPN_W     = ADDR_WIDTH - PAGE_BITS;
  localparam int PTE_BYTES = PTE_WIDTH / 8;
  localparam int RRW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int VW        = $clog2(TLB_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_e;
  state_e state_q, state_d;

  logic [TLB_SIZE-1:0]   ent_valid_q;
  logic [PPN_W-1:0]      ent_vpn_q [TLB_SIZE];
  logic [PPN_W-1:0]      ent_ppn_q [TLB_SIZE];
  logic [RRW-1:0]        rr_q, rr_d, gnt_q, gnt_d;
  logic [VW-1:0]         victim_q, fill_idx;
  logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d, pte_addr_q, pte_addr_d;
  logic                  pte_v_q;
  logic [PPN_W-1:0]      pte_ppn_q;
  logic                  flush_pend_q;
  logic [NUM_REQS-1:0]   hit, miss;
  logic [PPN_W-1:0]      ppn_sel [NUM_REQS];
  logic                  fill_we, grant_found, inv_found;
  int unsigned           idx;
  logic                  unused_pte;

  assign unused_pte = ^{bus.ptw_rsp_data[PTE_WIDTH-1:10+PPN_W], bus.ptw_rsp_data[9:1]};

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      ppn_sel[i] = '0;
      for (int unsigned e = 0; e < TLB_SIZE; e++) begin
        if (ent_valid_q[e] && ent_vpn_q[e] == bus.req_addr[i*ADDR_WIDTH+PAGE_BITS +: PPN_W]) begin
          hit[i]     = 1'b1;
          ppn_sel[i] = ppn_sel[i] | ent_ppn_q[e];
        end
      end
      bus.out_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = {ppn_sel[i], bus.req_addr[i*ADDR_WIDTH +: PAGE_BITS]};
    end
    miss          = bus.req_valid & ~hit;
    bus.out_valid = bus.req_valid & hit;
  end

  assign bus.out_tag      = bus.req_tag;
  assign bus.ptw_req_addr = pte_addr_q;
  assign fault_addr       = vaddr_q;
  assign busy             = (state_q != S_IDLE);

  // Prefer the lowest free slot so a cold TLB fills in order; fall back to the rotating victim.
  always_comb begin
    fill_idx  = victim_q;
    inv_found = 1'b0;
    for (int unsigned e = 0; e < TLB_SIZE; e++) begin
      if (!inv_found && !ent_valid_q[e]) begin
        inv_found = 1'b1;
        fill_idx  = VW'(e);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    rr_d              = rr_q;
    gnt_d             = gnt_q;
    vaddr_d           = vaddr_q;
    pte_addr_d        = pte_addr_q;
    bus.ptw_req_valid = 1'b0;
    bus.req_ready     = bus.out_ready & hit;
    fault_valid       = 1'b0;
    fill_we           = 1'b0;
    grant_found       = 1'b0;
    idx               = 0;
    case (state_q)
      S_IDLE: begin
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
          idx = (32'(rr_q) + k) % NUM_REQS;
          if (!grant_found && miss[idx]) begin
            grant_found = 1'b1;
            gnt_d       = RRW'(idx);
            rr_d        = RRW'((idx + 1) % NUM_REQS);
            vaddr_d     = bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
        if (grant_found) begin
          pte_addr_d = pt_base + ADDR_WIDTH'(vaddr_d >> PAGE_BITS) * ADDR_WIDTH'(PTE_BYTES);
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        bus.ptw_req_valid = 1'b1;
        if (bus.ptw_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.ptw_rsp_valid) state_d = S_FILL;
      end
      S_FILL: begin
        state_d = S_IDLE;
        if (pte_v_q) begin
          fill_we = !flush && !flush_pend_q;
        end else begin
          fault_valid          = 1'b1;
          bus.req_ready[gnt_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid_q  <= '0;
      rr_q         <= '0;
      gnt_q        <= '0;
      victim_q     <= '0;
      vaddr_q      <= '0;
      pte_addr_q   <= '0;
      pte_v_q      <= 1'b0;
      pte_ppn_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      vaddr_q    <= vaddr_d;
      pte_addr_q <= pte_addr_d;
      if (state_q == S_WAIT && bus.ptw_rsp_valid) begin
        pte_v_q   <= bus.ptw_rsp_data[0];
        pte_ppn_q <= bus.ptw_rsp_data[10 +: PPN_W];
      end
      // A flush seen mid-walk poisons that walk's fill; the marker dies with the walk.
      if (state_q == S_FILL)                 flush_pend_q <= 1'b0;
      else if (flush && state_q != S_IDLE)   flush_pend_q <= 1'b1;
      if (flush) begin
        ent_valid_q <= '0;
        victim_q    <= '0;
      end else if (fill_we) begin
        ent_valid_q[fill_idx] <= 1'b1;
        victim_q              <= victim_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      ent_vpn_q[fill_idx] <= vaddr_q[ADDR_WIDTH-1:PAGE_BITS];
      ent_ppn_q[fill_idx] <= pte_ppn_q;
    end
  end
endmodule

// File: tb/tb_vx_tlb_xlate.sv
// Directed bench for vx_tlb_xlate: hit table plus walk, fault, replacement, flush and reset sequences.
module tb_vx_tlb_xlate;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] pt_base;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        busy;
  int          tests = 0;
  int          fails = 0;

  vx_tlb_xlate_if #(.NUM_REQS(4), .ADDR_WIDTH(32), .TAG_WIDTH(16), .PTE_WIDTH(32)) bus ();

  vx_tlb_xlate #(
    .NUM_REQS(4), .ADDR_WIDTH(32), .TAG_WIDTH(16), .TLB_SIZE(16), .PAGE_BITS(12), .PTE_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .pt_base(pt_base), .bus(bus),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] vaddr;
    logic        ordy;
    logic        exp_v;
    logic        exp_r;
    logic [31:0] exp_pa;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [31:0] va);
    bus.req_valid[ch]         = 1'b1;
    bus.req_addr[ch*32 +: 32] = va;
    bus.req_tag[ch*16 +: 16]  = 16'hA000 + 16'(ch);
  endtask

  task automatic clr_req();
    bus.req_valid = '0;
  endtask

  function automatic logic [31:0] pa_of(input int ch);
    return bus.out_addr[ch*32 +: 32];
  endfunction

  // Present a request for one sub-cycle and withdraw it before the edge so no walk starts.
  task automatic probe(input string name, input int ch, input logic [31:0] va,
                       input logic exp_v, input logic [31:0] exp_pa);
    clr_req();
    set_req(ch, va);
    #1;
    chk({name, "_valid"}, 64'(bus.out_valid[ch]), 64'(exp_v));
    if (exp_v) chk({name, "_addr"}, 64'(pa_of(ch)), 64'(exp_pa));
    clr_req();
    step();
  endtask

  // Wait for the PTE fetch, check its address, accept it and return the PTE; returns in FILL.
  task automatic serve_walk(input string name, input logic [31:0] exp_pa, input logic [31:0] pte);
    int n = 0;
    while (!bus.ptw_req_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_ptw_valid"}, 64'(bus.ptw_req_valid), 64'd1);
    chk({name, "_ptw_addr"}, 64'(bus.ptw_req_addr), 64'(exp_pa));
    bus.ptw_req_ready = 1'b1;
    step();
    bus.ptw_req_ready = 1'b0;
    bus.ptw_rsp_valid = 1'b1;
    bus.ptw_rsp_data  = pte;
    step();
    bus.ptw_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'h0001_2FFC, 1'b1, 1'b1, 1'b1, 32'h0011_5FFC};
    vecs[1] = '{0, 32'h0001_2FFC, 1'b0, 1'b1, 1'b0, 32'h0011_5FFC};
    vecs[2] = '{0, 32'h0001_2FFC, 1'b1, 1'b1, 1'b1, 32'h0011_5FFC};
    vecs[3] = '{2, 32'h0002_0000, 1'b1, 1'b1, 1'b1, 32'h002A_3000};
    vecs[4] = '{2, 32'h0002_0000, 1'b0, 1'b1, 1'b0, 32'h002A_3000};
    vecs[5] = '{3, 32'h0001_2000, 1'b1, 1'b1, 1'b1, 32'h0011_5000};
    vecs[6] = '{1, 32'h0003_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    vecs[7] = '{1, 32'h0002_0FFF, 1'b1, 1'b1, 1'b1, 32'h002A_3FFF};

    reset = 1'b1; flush = 1'b0; pt_base = 32'h8000;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_tag = '0; bus.out_ready = '1;
    bus.ptw_req_ready = 1'b0; bus.ptw_rsp_valid = 1'b0; bus.ptw_rsp_data = '0;

    // Reset state, with requests offered on every channel
    for (int c = 0; c < 4; c++) set_req(c, 32'h0001_2345);
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ptw_valid", 64'(bus.ptw_req_valid), 64'd0);
    chk("rst_fault_valid", 64'(fault_valid), 64'd0);
    chk("rst_fault_addr", 64'(fault_addr), 64'd0);
    clr_req();
    step();
    reset = 1'b0;
    step();

    // Cold miss on ch0: visible exactly one cycle after FILL
    set_req(0, 32'h0001_2345);
    serve_walk("cold", 32'h0000_8048, 32'h0004_5401);
    chk("cold_fill_busy", 64'(busy), 64'd1);
    chk("cold_fill_nohit", 64'(bus.out_valid[0]), 64'd0);
    chk("cold_fill_nofault", 64'(fault_valid), 64'd0);
    step();
    chk("cold_hit_valid", 64'(bus.out_valid[0]), 64'd1);
    chk("cold_hit_addr", 64'(pa_of(0)), 64'h0011_5345);
    chk("cold_hit_tag", 64'(bus.out_tag[15:0]), 64'hA000);
    chk("cold_hit_ready", 64'(bus.req_ready[0]), 64'd1);
    chk("cold_idle", 64'(busy), 64'd0);
    clr_req();
    step();

    // Shared miss: ch1 and ch3 on VPN 0x20, single walk
    set_req(1, 32'h0002_0010);
    set_req(3, 32'h0002_0ABC);
    serve_walk("shared", 32'h0000_8080, 32'h000A_8C01);
    step();
    chk("shared_ch1_valid", 64'(bus.out_valid[1]), 64'd1);
    chk("shared_ch3_valid", 64'(bus.out_valid[3]), 64'd1);
    chk("shared_ch1_addr", 64'(pa_of(1)), 64'h002A_3010);
    chk("shared_ch3_addr", 64'(pa_of(3)), 64'h002A_3ABC);
    for (int k = 0; k < 3; k++) begin
      chk("shared_no_dup_walk", 64'(bus.ptw_req_valid), 64'd0);
      step();
    end
    clr_req();
    step();

    // Hit path table, out_ready toggling
    for (int v = 0; v < 8; v++) begin
      clr_req();
      bus.out_ready = '1;
      bus.out_ready[vecs[v].ch] = vecs[v].ordy;
      set_req(vecs[v].ch, vecs[v].vaddr);
      #1;
      chk($sformatf("vec%0d_valid", v), 64'(bus.out_valid[vecs[v].ch]), 64'(vecs[v].exp_v));
      chk($sformatf("vec%0d_ready", v), 64'(bus.req_ready[vecs[v].ch]), 64'(vecs[v].exp_r));
      if (vecs[v].exp_v) begin
        chk($sformatf("vec%0d_addr", v), 64'(pa_of(vecs[v].ch)), 64'(vecs[v].exp_pa));
        chk($sformatf("vec%0d_tag", v), 64'(bus.out_tag[vecs[v].ch*16 +: 16]),
            64'(16'hA000 + 16'(vecs[v].ch)));
      end
      chk($sformatf("vec%0d_no_walk", v), 64'(bus.ptw_req_valid), 64'd0);
      clr_req();
      step();
    end
    bus.out_ready = '1;

    // Fault on ch2: pulse, consume, no entry written
    set_req(2, 32'h0005_5123);
    serve_walk("fault", 32'h0000_8154, 32'h0000_0000);
    chk("fault_pulse", 64'(fault_valid), 64'd1);
    chk("fault_addr", 64'(fault_addr), 64'h0005_5123);
    chk("fault_consume", 64'(bus.req_ready[2]), 64'd1);
    chk("fault_no_out", 64'(bus.out_valid[2]), 64'd0);
    clr_req();
    step();
    chk("fault_pulse_end", 64'(fault_valid), 64'd0);
    chk("fault_idle", 64'(busy), 64'd0);
    probe("fault_no_entry", 2, 32'h0005_5123, 1'b0, 32'h0);

    // Round robin after grants ch0, ch1, ch2: ch3 wins over ch1, then ch1
    set_req(1, 32'h0004_0000);
    set_req(3, 32'h0004_1000);
    serve_walk("rr_first", 32'h0000_8104, 32'h0000_0000);
    chk("rr_first_addr", 64'(fault_addr), 64'h0004_1000);
    chk("rr_first_ready3", 64'(bus.req_ready[3]), 64'd1);
    chk("rr_first_ready1", 64'(bus.req_ready[1]), 64'd0);
    bus.req_valid[3] = 1'b0;
    serve_walk("rr_second", 32'h0000_8100, 32'h0000_0000);
    chk("rr_second_addr", 64'(fault_addr), 64'h0004_0000);
    chk("rr_second_ready1", 64'(bus.req_ready[1]), 64'd1);
    clr_req();
    step();

    // Flush in IDLE, then 17 distinct VPNs: the 17th evicts entry 0
    flush = 1'b1;
    step();
    flush = 1'b0;
    probe("flush_miss", 0, 32'h0001_2345, 1'b0, 32'h0);
    for (int k = 0; k < 17; k++) begin
      set_req(0, (32'h100 + 32'(k)) << 12);
      serve_walk($sformatf("repl%0d", k), 32'h8000 + (32'h100 + 32'(k)) * 4,
                 ((32'h300 + 32'(k)) << 10) | 32'h1);
      step();
      chk($sformatf("repl%0d_hit", k), 64'(pa_of(0)), 64'((32'h300 + 32'(k)) << 12));
      clr_req();
      step();
    end
    probe("repl_keep_101", 0, 32'h0010_1000, 1'b1, 32'h0030_1000);
    probe("repl_keep_110", 0, 32'h0011_0000, 1'b1, 32'h0031_0000);
    probe("repl_evicted_100", 0, 32'h0010_0000, 1'b0, 32'h0);
    set_req(0, 32'h0010_0000);
    serve_walk("repl_rewalk", 32'h0000_8400, (32'h3AA << 10) | 32'h1);
    step();
    chk("repl_rewalk_hit", 64'(pa_of(0)), 64'h003A_A000);
    clr_req();
    step();

    // Flush during WAIT: fill suppressed, channel re-walks
    set_req(0, 32'h0020_0000);
    step();
    chk("fw_req", 64'(bus.ptw_req_valid), 64'd1);
    bus.ptw_req_ready = 1'b1;
    step();
    bus.ptw_req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.ptw_rsp_valid = 1'b1;
    bus.ptw_rsp_data  = (32'h5 << 10) | 32'h1;
    step();
    bus.ptw_rsp_valid = 1'b0;
    step();
    chk("fw_suppressed", 64'(bus.out_valid[0]), 64'd0);
    serve_walk("fw_rewalk", 32'h0000_8800, (32'h5 << 10) | 32'h1);
    step();
    chk("fw_rewalk_valid", 64'(bus.out_valid[0]), 64'd1);
    chk("fw_rewalk_addr", 64'(pa_of(0)), 64'h0000_5000);
    clr_req();
    step();
    probe("fw_flushed_101", 1, 32'h0010_1000, 1'b0, 32'h0);

    // Async reset in WAIT; late response ignored
    set_req(2, 32'h0030_0000);
    step();
    bus.ptw_req_ready = 1'b1;
    step();
    bus.ptw_req_ready = 1'b0;
    chk("ar_busy_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    clr_req();
    #1;
    chk("ar_busy_now", 64'(busy), 64'd0);
    chk("ar_ptw_idle", 64'(bus.ptw_req_valid), 64'd0);
    step();
    reset = 1'b0;
    bus.ptw_rsp_valid = 1'b1;
    bus.ptw_rsp_data  = (32'h7 << 10) | 32'h1;
    step();
    bus.ptw_rsp_valid = 1'b0;
    chk("ar_rsp_ignored", 64'(busy), 64'd0);
    step();
    probe("ar_miss_ch2", 2, 32'h0030_0000, 1'b0, 32'h0);
    probe("ar_miss_ch0", 0, 32'h0000_5000, 1'b0, 32'h0);
    probe("ar_miss_ch1", 1, 32'h0031_0000, 1'b0, 32'h0);
    chk("ar_no_walk", 64'(bus.ptw_req_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
